// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one sequential 8x8 multiplier among N requesters. Requests are
//   arbitrated round-robin while idle; the winner's operands are latched and a
//   start pulse is issued, the arbiter then waits on mul_busy (bounded by a
//   watchdog) and returns the product to the winner as a one-cycle pulse.
//
// Ports
//   clk, resetH        clock (rising edge), asynchronous active-high reset
//   req[N]             per-requester request level
//   req_a/req_b[8N]    operands, requester i at bits [8i+7:8i]
//   grant[N]           one-hot pulse: operands accepted
//   rsp_valid[N]       one-hot pulse: response for requester i
//   rsp_data[16]       product, or 0 when the operation timed out
//   rsp_err            set with rsp_valid when the operation timed out
//   mul_start          one-cycle start pulse to the multiplier
//   mul_a/mul_b[8]     registered operands to the multiplier
//   mul_busy           multiplier busy
//   mul_out[16]        multiplier product, valid while mul_busy is low
//   ops_count[16]      completed operations, saturating
module mult_share_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             resetH,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   req_a,
  input  logic [8*N-1:0]   req_b,
  output logic [N-1:0]     grant,
  output logic [N-1:0]     rsp_valid,
  output logic [15:0]      rsp_data,
  output logic             rsp_err,
  output logic             mul_start,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic             mul_busy,
  input  logic [15:0]      mul_out,
  output logic [15:0]      ops_count
);

  localparam int          IDW = (N > 1) ? $clog2(N) : 1;
  localparam int          TW  = $clog2(TIMEOUT);
  localparam int unsigned NU  = N;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   id, last, winner;
  logic             found;
  logic [7:0]       win_a, win_b;
  logic [TW-1:0]    tcnt;
  logic             tmo;
  int unsigned      idx;

  // Round-robin search starting just after the last winner.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NU; k++) begin
      idx = (32'(last) + k) % NU;
      if (!found && req[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (IDW'(i) == winner) begin
        win_a = req_a[8*i +: 8];
        win_b = req_b[8*i +: 8];
      end
    end
  end

  assign tmo = (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nx  = state;
    grant     = '0;
    rsp_valid = '0;
    mul_start = 1'b0;
    case (state)
      IDLE:  if (found) state_nx = ISSUE;
      ISSUE: begin
        grant[id] = 1'b1;
        mul_start = 1'b1;
        state_nx  = WAIT;
      end
      WAIT:  if (!mul_busy || tmo) state_nx = RESP;
      RESP: begin
        rsp_valid[id] = 1'b1;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      state     <= IDLE;
      last      <= IDW'(N - 1);
      id        <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      tcnt      <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      ops_count <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (found) begin
            id    <= winner;
            last  <= winner;
            mul_a <= win_a;
            mul_b <= win_b;
          end
        end
        ISSUE: tcnt <= '0;
        WAIT: begin
          if (!mul_busy) begin
            rsp_data <= mul_out;
            rsp_err  <= 1'b0;
          end else if (tmo) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESP: if (ops_count != '1) ops_count <= ops_count + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomised scoreboard bench for mult_share_arbiter with a behavioural
// multiplier and a queue-based round-robin reference model.
module tb_mult_share_arbiter;
  localparam int N       = 4;
  localparam int TIMEOUT = 64;
  localparam int PER     = 10;

  logic             clk, resetH;
  logic [N-1:0]     req;
  logic [8*N-1:0]   req_a, req_b;
  logic [N-1:0]     grant, rsp_valid;
  logic [15:0]      rsp_data;
  logic             rsp_err, mul_start;
  logic [7:0]       mul_a, mul_b;
  logic             mul_busy;
  logic [15:0]      mul_out, ops_count;

  mult_share_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetH(resetH), .req(req), .req_a(req_a), .req_b(req_b),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_busy(mul_busy),
    .mul_out(mul_out), .ops_count(ops_count)
  );

  typedef struct { int id; int prod; } exp_t;
  typedef struct { int lat; bit hang; time t; } mop_t;
  typedef struct { logic [7:0] a; logic [7:0] b; } op_t;

  exp_t       sb[$];
  mop_t       latq[$];
  op_t        rq[N][$];

  int         vectors = 0;
  int         miscompares = 0;
  logic [N-1:0] exp_grant;
  bit         model_idle, rsp_seen, ops_pend, hang, withdraw;
  int         last_m, exp_ops, lat_fix;

  initial begin
    clk = 1'b1;
    forever #(PER/2) clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int rr(input int lst, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int j = (lst + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit all_idle();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) e = 1'b0;
    return e && (req == '0) && (sb.size() == 0) && (latq.size() == 0) && model_idle && !ops_pend;
  endfunction

  task automatic push(input int i, input int a, input int b);
    op_t o;
    o.a = 8'(a);
    o.b = 8'(b);
    rq[i].push_back(o);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      @(negedge clk); #3;
      n++;
    end
    chk("drain_done", 32'(n < budget), 32'd1);
  endtask

  // Requesters and arbitration model: outputs are checked, then requests are
  // updated, then the expected winner for the next edge is decided.
  initial begin : driver
    int w, pa, pb;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetH) begin
        chk("grant", 32'(grant), 32'(exp_grant));
        chk("mul_start", 32'(mul_start), 32'(exp_grant != '0));
      end
      for (int i = 0; i < N; i++) begin
        if (grant[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        else if (withdraw && req[i] && rq[i].size() > 0 && $urandom_range(0, 19) == 0)
          void'(rq[i].pop_front());
      end
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() > 0) begin
          req[i] = 1'b1;
          req_a[8*i +: 8] = rq[i][0].a;
          req_b[8*i +: 8] = rq[i][0].b;
        end else begin
          req[i] = 1'b0;
          req_a[8*i +: 8] = '0;
          req_b[8*i +: 8] = '0;
        end
      end
      exp_grant = '0;
      if (model_idle && req != '0 && !resetH) begin
        w = rr(last_m, req);
        last_m = w;
        exp_grant[w] = 1'b1;
        pa = int'(req_a[8*w +: 8]);
        pb = int'(req_b[8*w +: 8]);
        e.id = w;
        e.prod = pa * pb;
        sb.push_back(e);
        model_idle = 1'b0;
      end
      if (rsp_seen) begin
        model_idle = 1'b1;
        rsp_seen = 1'b0;
      end
    end
  end

  // Behavioural multiplier: busy for a chosen number of cycles after start.
  initial begin : mult_model
    logic st;
    logic [7:0] ca, cb, pa, pb;
    int rem, lat;
    time t;
    mop_t m;
    mul_busy = 1'b0;
    mul_out = '0;
    rem = 0;
    pa = '0;
    pb = '0;
    forever begin
      @(negedge clk);
      st = mul_start; ca = mul_a; cb = mul_b;
      @(posedge clk);
      t = $time;
      #1;
      if (resetH) begin
        mul_busy = 1'b0;
        rem = 0;
      end else if (st) begin
        pa = ca; pb = cb;
        lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 10));
        m.lat = lat; m.hang = hang; m.t = t;
        latq.push_back(m);
        if (hang) begin
          mul_busy = 1'b1; rem = -1; mul_out = 16'($urandom);
        end else if (lat == 0) begin
          mul_busy = 1'b0; rem = 0; mul_out = 16'(pa) * 16'(pb);
        end else begin
          mul_busy = 1'b1; rem = lat; mul_out = 16'($urandom);
        end
      end else if (mul_busy && rem > 0) begin
        rem--;
        if (rem == 0) begin
          mul_busy = 1'b0;
          mul_out = 16'(pa) * 16'(pb);
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    mop_t m;
    time tr;
    forever begin
      @(posedge clk);
      tr = $time;
      #1;
      if (ops_pend) begin
        chk("ops_count", 32'(ops_count), 32'(exp_ops));
        ops_pend = 1'b0;
      end
      if (!resetH && rsp_valid != '0) begin
        rsp_seen = 1'b1;
        if (sb.size() == 0 || latq.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          m = latq.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
          chk("rsp_data", 32'(rsp_data), m.hang ? 32'd0 : 32'(e.prod));
          chk("rsp_err", 32'(rsp_err), 32'(m.hang));
          chk("rsp_latency", 32'(int'((tr - m.t) / PER)), m.hang ? 32'(TIMEOUT) : 32'(m.lat + 1));
          if (exp_ops < 16'hFFFF) exp_ops++;
          ops_pend = 1'b1;
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_mul_start"}, 32'(mul_start), 32'd0);
    chk({tag, "_mul_ab"}, {16'd0, mul_a, mul_b}, 32'd0);
    chk({tag, "_ops_count"}, 32'(ops_count), 32'd0);
  endtask

  initial begin : main
    bit seen;
    resetH = 1'b1;
    req = '0; req_a = '0; req_b = '0;
    exp_grant = '0; model_idle = 1'b1; rsp_seen = 1'b0; ops_pend = 1'b0;
    hang = 1'b0; withdraw = 1'b0; last_m = N - 1; exp_ops = 0; lat_fix = -1;
    #3;
    check_zero("reset");
    #12 resetH = 1'b0;

    // single op, 8 busy cycles
    lat_fix = 8;
    push(0, 5, 5);
    drain(200);
    chk("single_ops_count", 32'(ops_count), 32'd1);

    // simultaneous requesters 0 and 2
    lat_fix = -1;
    push(0, 3, 4); push(2, 7, 9);
    drain(300);

    // round robin after serving 1, then all four continuously
    push(1, 6, 7); drain(200);
    push(0, 10, 11); push(1, 12, 13); drain(300);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) push(i, $urandom_range(0, 255), $urandom_range(0, 255));
    drain(1000);

    // boundaries: max operands, zero latency, longest non-timeout latency
    push(3, 255, 255); drain(200);
    lat_fix = 0; push(2, 0, 200); push(1, 17, 15); drain(200);
    lat_fix = TIMEOUT - 1; push(0, 100, 3); drain(400);

    // watchdog, then recovery
    lat_fix = -1; hang = 1'b1;
    push(2, 9, 9); drain(400);
    hang = 1'b0;
    push(3, 8, 8); drain(200);

    // reset three cycles into WAIT
    lat_fix = 30;
    push(1, 11, 13);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk); #3;
      if (mul_start) seen = 1'b1;
    end
    chk("reset_op_started", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    #2 resetH = 1'b1;
    #1 check_zero("midreset");
    for (int i = 0; i < N; i++) rq[i].delete();
    sb.delete(); latq.delete();
    req = '0; req_a = '0; req_b = '0;
    exp_grant = '0; model_idle = 1'b1; rsp_seen = 1'b0; ops_pend = 1'b0;
    last_m = N - 1; exp_ops = 0;
    repeat (2) @(posedge clk);
    chk("midreset_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #2 resetH = 1'b0;
    lat_fix = -1;
    push(3, 4, 5); push(1, 2, 3);
    drain(300);

    // random traffic with occasional withdrawn requests
    withdraw = 1'b1;
    for (int k = 0; k < 150; k++) begin
      push($urandom_range(0, N - 1), $urandom_range(0, 255), $urandom_range(0, 255));
      repeat ($urandom_range(0, 10)) @(negedge clk);
      #3;
    end
    drain(20000);
    withdraw = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
